// File: rtl/data_writeback_mem_responder_pkg.sv
// ============================================================================
// Module   : data_writeback_mem_pkg
// Brief    : Shared state/operation types and offset-width helper for the
//            write-back data cache memory responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package data_writeback_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int DEFAULT_BLOCKSIZE = 4;

  function automatic int word_off_w(input int blocksize);
    return (blocksize > 1) ? $clog2(blocksize) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_writeback_mem_responder_if.sv
// ============================================================================
// Module   : data_writeback_mem_responder_if
// Brief    : Cache-controller <-> memory-responder burst bus.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface data_writeback_mem_responder_if
  import data_writeback_mem_pkg::*;
#(
  parameter int BLOCKSIZE = DEFAULT_BLOCKSIZE
) ();

  logic                              MemRE;
  logic                              MemWE;
  logic [31:0]                       MemA;
  logic [31:0]                       MemWD;
  logic [31:0]                       MemRD;
  logic                              BusReady;
  logic [word_off_w(BLOCKSIZE)-1:0]  WordOffset;
  logic                              BurstDone;
  logic                              Busy;

  modport master (
    output MemRE, MemWE, MemA, MemWD,
    input  MemRD, BusReady, WordOffset, BurstDone, Busy
  );

  modport slave (
    input  MemRE, MemWE, MemA, MemWD,
    output MemRD, BusReady, WordOffset, BurstDone, Busy
  );

endinterface

`default_nettype wire

// File: rtl/data_writeback_mem_responder_array.sv
// ============================================================================
// Module   : data_writeback_mem_array
// Brief    : Single-port MEMWORDS x 32 store, combinational read, no reset;
//            mem_q may be preloaded by a simulation harness.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_writeback_mem_array #(
  parameter int MEMWORDS = 16384,
  parameter int AW       = $clog2(MEMWORDS)
) (
  input  wire logic          clk,
  input  wire logic          we_i,
  input  wire logic [AW-1:0] addr_i,
  input  wire logic [31:0]   wdata_i,
  output logic      [31:0]   rdata_o
);

  logic [31:0] mem_q [MEMWORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/data_writeback_mem_responder.sv
// ============================================================================
// Module   : data_writeback_mem_responder
// Brief    : Burst memory responder for line fills and dirty writebacks.
//            Optional macro MEM_CRITICAL_WORD_FIRST_EN: reads start at the
//            requested word and wrap within the line.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_writeback_mem_responder
  import data_writeback_mem_pkg::*;
#(
  parameter int BLOCKSIZE = 4,
  parameter int LATENCY   = 3,
  parameter int MEMWORDS  = 16384
) (
  input  wire logic                      clk,
  input  wire logic                      reset,
  data_writeback_mem_responder_if.slave  bus
);

  localparam int OW = word_off_w(BLOCKSIZE);
  localparam int AW = $clog2(MEMWORDS);
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_WAIT  = ST_WAIT;
  localparam logic [1:0] S_BURST = ST_BURST;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]    state_q, state_d;
  op_e           op_q, op_d;
  logic [AW-1:0] base_q, base_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;

  logic [OW-1:0] w_start;
  logic [OW-1:0] w_off;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;
  logic          w_ready;
  logic          w_we;
  logic          w_unused;

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  logic [OW-1:0] crit_q, crit_d;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    crit_d  = crit_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.MemRE || bus.MemWE) begin
          // Writeback must drain before a fill of the same victim slot.
          op_d   = bus.MemWE ? OP_WRITE : OP_READ;
          base_d = bus.MemA[AW+1:2] & ~AW'(BLOCKSIZE - 1);
`ifdef MEM_CRITICAL_WORD_FIRST_EN
          crit_d = bus.MemA[OW+1:2];
`endif
          cnt_d   = '0;
          lat_d   = '0;
          state_d = (LATENCY == 0) ? S_BURST : S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == LW'(LATENCY - 1)) begin
          state_d = S_BURST;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_BURST: begin
        cnt_d = cnt_q + OW'(1);
        if (cnt_q == OW'(BLOCKSIZE - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_READ;
      base_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
      crit_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
`ifdef MEM_CRITICAL_WORD_FIRST_EN
      crit_q  <= crit_d;
`endif
    end
  end

`ifdef MEM_CRITICAL_WORD_FIRST_EN
  assign w_start = (op_q == OP_READ) ? crit_q : '0;
`else
  assign w_start = '0;
`endif

  assign w_ready = (state_q == S_BURST);
  assign w_off   = w_start + cnt_q;
  assign w_idx   = base_q + AW'(w_off);
  assign w_we    = w_ready && (op_q == OP_WRITE);

  data_writeback_mem_array #(
    .MEMWORDS (MEMWORDS),
    .AW       (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (w_we),
    .addr_i  (w_idx),
    .wdata_i (bus.MemWD),
    .rdata_o (w_rdata)
  );

  assign bus.BusReady   = w_ready;
  assign bus.BurstDone  = w_ready && (cnt_q == OW'(BLOCKSIZE - 1));
  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.WordOffset = w_off;
  assign bus.MemRD      = (w_ready && (op_q == OP_READ)) ? w_rdata : 32'd0;

  assign w_unused = ^{bus.MemA[31:AW+2], bus.MemA[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_data_writeback_mem_responder.sv
// ============================================================================
// Module   : tb_data_writeback_mem_responder
// Brief    : Directed bursts against a latency-3 and a latency-0/16-word DUT.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_writeback_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel, re, we;
  logic [31:0] addr, wd;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  data_writeback_mem_responder_if #(.BLOCKSIZE(4)) if_a ();
  data_writeback_mem_responder_if #(.BLOCKSIZE(4)) if_b ();

  assign if_a.MemRE = re & ~sel;
  assign if_a.MemWE = we & ~sel;
  assign if_a.MemA  = addr;
  assign if_a.MemWD = wd;
  assign if_b.MemRE = re & sel;
  assign if_b.MemWE = we & sel;
  assign if_b.MemA  = addr;
  assign if_b.MemWD = wd;

  logic        rdy, done, busy;
  logic [1:0]  off;
  logic [31:0] rd;
  assign rdy  = sel ? if_b.BusReady   : if_a.BusReady;
  assign done = sel ? if_b.BurstDone  : if_a.BurstDone;
  assign busy = sel ? if_b.Busy       : if_a.Busy;
  assign off  = sel ? if_b.WordOffset : if_a.WordOffset;
  assign rd   = sel ? if_b.MemRD      : if_a.MemRD;

  data_writeback_mem_responder #(.BLOCKSIZE(4), .LATENCY(3), .MEMWORDS(16384)) dut_a (
    .clk (clk), .reset (reset), .bus (if_a.slave)
  );

  data_writeback_mem_responder #(.BLOCKSIZE(4), .LATENCY(0), .MEMWORDS(16)) dut_b (
    .clk (clk), .reset (reset), .bus (if_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Issue one request and check every cycle until the responder is idle again.
  // abort >= 0 pulls reset low during that beat and ends the burst there.
  task automatic burst(input string nm, input logic s, input logic r, input logic w,
                       input logic [31:0] a, input int lat, input logic [127:0] wdat,
                       input logic [127:0] rexp, input logic [7:0] oexp, input int abort);
    @(negedge clk);
    sel = s; re = r; we = w; addr = a;
    @(posedge clk);
    for (int c = 1; c <= lat + 6; c++) begin
      int b = c - lat - 1;
      @(negedge clk);
      re = 1'b0; we = 1'b0; addr = 32'hFFFF_FFFC;
      chk({nm, ":rdy"},  32'(rdy),  32'(b >= 0 && b < 4));
      chk({nm, ":busy"}, 32'(busy), 32'(c <= lat + 5));
      chk({nm, ":done"}, 32'(done), 32'(b == 3));
      if (b >= 0 && b < 4) begin
        chk({nm, ":off"}, 32'(off), 32'(oexp[2*b +: 2]));
        chk({nm, ":rd"},  rd,       rexp[32*b +: 32]);
        wd = wdat[32*b +: 32];
      end else begin
        chk({nm, ":rd0"}, rd, 32'd0);
      end
      if (b == abort) begin
        reset = 1'b0;
        #1;
        chk({nm, ":rst_rdy"},  32'(rdy),  32'd0);
        chk({nm, ":rst_done"}, 32'(done), 32'd0);
        chk({nm, ":rst_busy"}, 32'(busy), 32'd0);
        chk({nm, ":rst_off"},  32'(off),  32'd0);
        chk({nm, ":rst_rd"},   rd,        32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    sel = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wd = '0;
    repeat (2) @(negedge clk);
    chk("reset:rdy",  32'(rdy),  32'd0);
    chk("reset:busy", 32'(busy), 32'd0);
    chk("reset:done", 32'(done), 32'd0);
    chk("reset:off",  32'(off),  32'd0);
    chk("reset:rd",   rd,        32'd0);
    reset = 1'b1;

    burst("wb40", 1'b0, 1'b0, 1'b1, 32'h40, 3,
          {32'hA3, 32'hA2, 32'hA1, 32'hA0}, '0, 8'hE4, -1);
`ifdef MEM_CRITICAL_WORD_FIRST_EN
    burst("rd4C", 1'b0, 1'b1, 1'b0, 32'h4C, 3,
          '0, {32'hA2, 32'hA1, 32'hA0, 32'hA3}, 8'h93, -1);
`else
    burst("rd4C", 1'b0, 1'b1, 1'b0, 32'h4C, 3,
          '0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'hE4, -1);
`endif

    burst("both100", 1'b0, 1'b1, 1'b1, 32'h100, 3,
          {32'hC3, 32'hC2, 32'hC1, 32'hC0}, '0, 8'hE4, -1);
    burst("rd100", 1'b0, 1'b1, 1'b0, 32'h100, 3,
          '0, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 8'hE4, -1);

    burst("wr200", 1'b0, 1'b0, 1'b1, 32'h200, 3,
          {32'hD3, 32'hD2, 32'hD1, 32'hD0}, '0, 8'hE4, -1);
    burst("ab200", 1'b0, 1'b0, 1'b1, 32'h200, 3,
          {32'hE3, 32'hE2, 32'hE1, 32'hE0}, '0, 8'hE4, 2);
    burst("rd200", 1'b0, 1'b1, 1'b0, 32'h200, 3,
          '0, {32'hD3, 32'hD2, 32'hE1, 32'hE0}, 8'hE4, -1);

    burst("wb_b40", 1'b1, 1'b0, 1'b1, 32'h40, 0,
          {32'h14, 32'h13, 32'h12, 32'h11}, '0, 8'hE4, -1);
    burst("rd_b00", 1'b1, 1'b1, 1'b0, 32'h00, 0,
          '0, {32'h14, 32'h13, 32'h12, 32'h11}, 8'hE4, -1);

`ifdef MEM_CRITICAL_WORD_FIRST_EN
    burst("wbB40", 1'b0, 1'b0, 1'b1, 32'h40, 3,
          {32'hB3, 32'hB2, 32'hB1, 32'hB0}, '0, 8'hE4, -1);
    burst("rdB48", 1'b0, 1'b1, 1'b0, 32'h48, 3,
          '0, {32'hB1, 32'hB0, 32'hB3, 32'hB2}, 8'h4E, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_writeback_mem_responder.md
Name: data_writeback_mem_responder

Overview:
- Memory-side responder for the write-back data cache. It serves line fills (read bursts) and dirty-line writebacks (write bursts) issued by the cache controller.
- Holds a word-addressed backing store and returns or accepts one 32-bit word per cycle after a fixed access latency.
- Sits between the data cache controller and the top level, replacing a flat single-cycle data memory.

Parameters:
- blocksize, 4, words per cache line (power of 2, at least 2)
- latency, 3, idle cycles between request accept and first data beat (0 allowed)
- memwords, 16384, backing-store depth in 32-bit words (power of 2)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- MemRE  input  1  line-fill request
- MemWE  input  1  writeback request
- MemA  input  32  byte address of any word in the target line
- MemWD  input  32  writeback data, one word per BusReady beat
- MemRD  output  32  fill data, valid when BusReady is high during a read burst
- BusReady  output  1  data beat handshake; one word transferred per high cycle
- WordOffset  output  $clog2(blocksize)  index of the word in the current beat
- BurstDone  output  1  high on the final beat only
- Busy  output  1  high in every state except IDLE

Behaviour:
- State machine:
  - IDLE -> WAIT when MemRE or MemWE is sampled high. If latency is 0, IDLE goes directly to BURST.
  - WAIT -> BURST after latency cycles.
  - BURST -> DONE after blocksize beats.
  - DONE -> IDLE after 1 cycle.
- On accept, the responder latches:
  - the operation; if MemRE and MemWE are both high, the write wins (writeback precedes fill).
  - the line base = MemA[31:2] with the low $clog2(blocksize) bits cleared.
  - the critical offset = MemA[$clog2(blocksize)+1:2].
- Requests are ignored outside IDLE. Changes on MemRE, MemWE or MemA after accept have no effect.
- First BusReady cycle: latency+1 cycles after the accept edge. BusReady then stays high for exactly blocksize consecutive cycles; there are no stalls.
- Beat counter: cnt runs 0..blocksize-1. WordOffset = (start + cnt) mod blocksize, where start = 0 (see the optional feature).
- Array index = (line base + WordOffset) mod memwords, taking the low $clog2(memwords) bits. Addresses beyond the array wrap.
- Read burst: MemRD = array[index], read combinationally. MemRD = 0 whenever BusReady is low or the burst is a write.
- Write burst: array[index] <= MemWD on each clock edge where BusReady is high.
- BurstDone = BusReady & (cnt == blocksize-1).
- DONE is a one-cycle guard. It lets the controller drop its request, so the same request cannot be re-accepted.
- Reset (asserted low, at any time including mid-burst):
  - State goes to IDLE; cnt, latched fields and the latency counter clear.
  - Outputs go to BusReady=0, BurstDone=0, Busy=0, WordOffset=0, MemRD=0.
  - Array contents are not reset. Words already written in an aborted write burst stay written.

Optional Feature:
- Macro: MEM_CRITICAL_WORD_FIRST_EN
- Defined: read bursts use start = latched critical offset, and WordOffset wraps modulo blocksize. For example, offset 2 with blocksize 4 gives the order 2,3,0,1. Write bursts still start at 0.
- Undefined: every burst starts at offset 0, and the critical offset is not stored.

Decomposition:
- Package data_writeback_mem_pkg holds:
  - typedef enum for the states IDLE/WAIT/BURST/DONE
  - typedef enum for the operation OP_READ/OP_WRITE
  - a word-offset width localparam helper
- One sub-module, data_writeback_mem_array: single-port, memwords x 32, combinational read, synchronous write enable, no reset. It supports $readmemh preload under simulation.

Test Plan:
- Write then read, latency=3, blocksize=4:
  - Writeback to MemA=0x00000040 with MemWD 0xA0,0xA1,0xA2,0xA3 -> BusReady high in cycles 4-7 after accept, BurstDone in cycle 7, Busy low 2 cycles after BurstDone.
  - Then a fill from MemA=0x0000004C -> MemRD 0xA0..0xA3 with WordOffset 0..3 (feature off).
- Latency 0: fill request -> BusReady high in the first cycle after accept, 4 beats, no WAIT state visited.
- Simultaneous MemRE=MemWE=1 at 0x100 -> treated as a write. The array updates; MemRD stays 0 throughout.
- Reset asserted low during beat 2 of a write to 0x200 -> all outputs 0 immediately. Words 0-1 are updated, words 2-3 keep their old values. A new request after reset is released is accepted normally.
- Address wrap with memwords=16: write 0x11,0x12,0x13,0x14 to MemA=0x40, then read MemA=0x00 -> returns 0x11..0x14.
- MEM_CRITICAL_WORD_FIRST_EN defined: fill from 0x48 with line data 0xB0..0xB3 -> WordOffset 2,3,0,1 and MemRD 0xB2,0xB3,0xB0,0xB1; BurstDone on the 0xB1 beat.
